// File: rtl/mem_arbiter_pkg.sv
// Shared CPU constants for the memory arbiter: FSM state encoding, memory
// work-type sizes and the last-grant flag.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_BUSY_I = 2'b01;
  localparam logic [1:0] ST_BUSY_D = 2'b10;

  localparam logic [1:0] WT_BYTE = 2'b00;
  localparam logic [1:0] WT_HALF = 2'b01;
  localparam logic [1:0] WT_WORD = 2'b10;

  // Instruction fetches are always unsigned word reads.
  localparam logic [2:0] IFETCH_WORK_TYPE = {1'b0, WT_WORD};

  typedef enum logic {
    GNT_IFETCH = 1'b0,
    GNT_DATA   = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (ifetch / data) arbiter in front of a single memory controller.
// Issues one transaction from IDLE, then waits in BUSY_I or BUSY_D for completion.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_type,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mc_new_task,
  output logic        mc_is_write,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_data_in,
  output logic [2:0]  mc_work_type,
  input  logic [31:0] mc_data_out,
  input  logic        mc_ready,
  input  logic        mc_working,
  input  logic        io_buffer_full
);

  logic [1:0] state_r;
  grant_e     last_grant_r;
  logic       busy_write_r;

  logic       issue_en_s;
  logic       io_hold_s;
  logic       i_ok_s;
  logic       d_ok_s;
  logic       gnt_i_s;
  logic       gnt_d_s;

  // Grant selection and same-cycle issue payload toward the memory controller.
  always_comb begin
    issue_en_s   = rst_in && rdy_in && (state_r == ST_IDLE);
    io_hold_s    = d_write && (d_addr[17:16] == IO_HI) && io_buffer_full;
    // A flush blocks every read; stores are architecturally committed and may go.
    i_ok_s       = issue_en_s && i_valid && !rob_clear;
    d_ok_s       = issue_en_s && d_valid && !io_hold_s && (d_write || !rob_clear);
    gnt_i_s      = 1'b0;
    gnt_d_s      = 1'b0;
    mc_new_task  = 1'b0;
    mc_is_write  = 1'b0;
    mc_addr      = 32'd0;
    mc_data_in   = 32'd0;
    mc_work_type = 3'd0;
    if (i_ok_s && d_ok_s) begin
      if (last_grant_r == GNT_IFETCH) begin
        gnt_d_s = 1'b1;
      end else begin
        gnt_i_s = 1'b1;
      end
    end else begin
      gnt_i_s = i_ok_s;
      gnt_d_s = d_ok_s;
    end
    if (gnt_i_s) begin
      mc_new_task  = 1'b1;
      mc_is_write  = 1'b0;
      mc_addr      = i_addr;
      mc_work_type = IFETCH_WORK_TYPE;
    end else if (gnt_d_s) begin
      mc_new_task  = 1'b1;
      mc_is_write  = d_write;
      mc_addr      = d_addr;
      mc_data_in   = d_wdata;
      mc_work_type = d_type;
    end else begin
      mc_new_task  = 1'b0;
    end
  end

  // FSM, last-grant flag and registered completion outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r      <= ST_IDLE;
      last_grant_r <= GNT_IFETCH;
      busy_write_r <= 1'b0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      i_data       <= 32'd0;
      d_rdata      <= 32'd0;
    end else if (!rdy_in) begin
      // Stalled: everything holds, but a done pulse must not be seen twice.
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_i_s) begin
            state_r      <= ST_BUSY_I;
            last_grant_r <= GNT_IFETCH;
          end else if (gnt_d_s) begin
            state_r      <= ST_BUSY_D;
            last_grant_r <= GNT_DATA;
            busy_write_r <= d_write;
          end
        end
        ST_BUSY_I: begin
          if (rob_clear) begin
            state_r <= ST_IDLE;
          end else if (mc_ready) begin
            i_done  <= 1'b1;
            i_data  <= mc_data_out;
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY_D: begin
          if (busy_write_r) begin
            if (!mc_working) begin
              d_done  <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else if (rob_clear) begin
            state_r <= ST_IDLE;
          end else if (mc_ready) begin
            d_done  <= 1'b1;
            d_rdata <= mc_data_out;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the memory controller side is
// driven by hand, cycle by cycle, with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_data;
  logic        d_valid;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_type;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mc_new_task;
  logic        mc_is_write;
  logic [31:0] mc_addr;
  logic [31:0] mc_data_in;
  logic [2:0]  mc_work_type;
  logic [31:0] mc_data_out;
  logic        mc_ready;
  logic        mc_working;
  logic        io_buffer_full;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.IO_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .i_valid(i_valid), .i_addr(i_addr), .i_done(i_done), .i_data(i_data),
    .d_valid(d_valid), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_type(d_type), .d_done(d_done), .d_rdata(d_rdata),
    .mc_new_task(mc_new_task), .mc_is_write(mc_is_write), .mc_addr(mc_addr),
    .mc_data_in(mc_data_in), .mc_work_type(mc_work_type), .mc_data_out(mc_data_out),
    .mc_ready(mc_ready), .mc_working(mc_working), .io_buffer_full(io_buffer_full)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
    i_valid = 1'b0; i_addr = 32'd0;
    d_valid = 1'b0; d_write = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_type = 3'd0;
    mc_data_out = 32'd0; mc_ready = 1'b0; mc_working = 1'b0; io_buffer_full = 1'b0;

    // Reset state, with requests pending to prove nothing issues under reset.
    #11;
    i_valid = 1'b1; d_valid = 1'b1;
    settle();
    chk1("rst_i_done", i_done, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk32("rst_i_data", i_data, 32'd0);
    chk32("rst_d_rdata", d_rdata, 32'd0);
    chk1("rst_new_task", mc_new_task, 1'b0);
    i_valid = 1'b0; d_valid = 1'b0;
    rst_in = 1'b1;

    // Both valid from reset: data, then ifetch, then data.
    tick();
    i_valid = 1'b1; i_addr = 32'h0000_2000;
    d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h0000_0400; d_type = 3'b010;
    settle();
    chk1("tie1_new_task", mc_new_task, 1'b1);
    chk32("tie1_addr_data", mc_addr, 32'h0000_0400);
    chk1("tie1_is_write", mc_is_write, 1'b0);
    tick();
    mc_ready = 1'b1; mc_data_out = 32'h1111_2222;
    settle();
    chk1("busy_no_issue", mc_new_task, 1'b0);
    tick();
    mc_ready = 1'b0;
    settle();
    chk1("tie1_d_done", d_done, 1'b1);
    chk32("tie1_d_rdata", d_rdata, 32'h1111_2222);
    chk1("tie1_no_i_done", i_done, 1'b0);
    chk1("tie2_new_task", mc_new_task, 1'b1);
    chk32("tie2_addr_ifetch", mc_addr, 32'h0000_2000);
    chk32("tie2_work_type", {29'd0, mc_work_type}, 32'h0000_0002);
    tick();
    mc_ready = 1'b1; mc_data_out = 32'h3333_4444;
    settle();
    chk1("tie2_d_done_pulse", d_done, 1'b0);
    tick();
    mc_ready = 1'b0;
    settle();
    chk1("tie2_i_done", i_done, 1'b1);
    chk32("tie2_i_data", i_data, 32'h3333_4444);
    chk32("tie3_addr_data", mc_addr, 32'h0000_0400);
    tick();
    i_valid = 1'b0; d_valid = 1'b0;
    mc_ready = 1'b1; mc_data_out = 32'h5555_6666;
    tick();
    mc_ready = 1'b0;
    settle();
    chk1("tie3_d_done", d_done, 1'b1);
    chk32("tie3_d_rdata", d_rdata, 32'h5555_6666);

    // Lone ifetch, word 0xDEADBEEF, memory answers 3 cycles after issue.
    tick();
    i_valid = 1'b1; i_addr = 32'h0000_1000;
    settle();
    chk1("if_new_task", mc_new_task, 1'b1);
    chk32("if_addr", mc_addr, 32'h0000_1000);
    chk32("if_work_type", {29'd0, mc_work_type}, 32'h0000_0002);
    chk1("if_is_write", mc_is_write, 1'b0);
    tick();
    tick();
    tick();
    mc_ready = 1'b1; mc_data_out = 32'hDEAD_BEEF;
    settle();
    chk1("if_early_done", i_done, 1'b0);
    tick();
    mc_ready = 1'b0; i_valid = 1'b0;
    settle();
    chk1("if_i_done", i_done, 1'b1);
    chk32("if_i_data", i_data, 32'hDEAD_BEEF);
    tick();
    settle();
    chk1("if_done_once", i_done, 1'b0);

    // Byte store to the I/O region held by a full buffer for 5 cycles.
    d_valid = 1'b1; d_write = 1'b1; d_addr = 32'h0003_0000; d_wdata = 32'h0000_00AB;
    d_type = 3'b000; io_buffer_full = 1'b1;
    settle();
    chk1("io_hold0", mc_new_task, 1'b0);
    for (int k = 1; k < 5; k++) begin
      tick();
      settle();
      chk1("io_hold", mc_new_task, 1'b0);
    end
    tick();
    io_buffer_full = 1'b0;
    settle();
    chk1("io_new_task", mc_new_task, 1'b1);
    chk1("io_is_write", mc_is_write, 1'b1);
    chk32("io_addr", mc_addr, 32'h0003_0000);
    chk32("io_wdata", mc_data_in, 32'h0000_00AB);
    chk32("io_work_type", {29'd0, mc_work_type}, 32'h0000_0000);
    tick();
    rob_clear = 1'b1; mc_working = 1'b0;
    settle();
    chk1("io_d_done_early", d_done, 1'b0);
    tick();
    rob_clear = 1'b0; d_valid = 1'b0; d_write = 1'b0;
    settle();
    chk1("io_d_done", d_done, 1'b1);

    // Flush two cycles into a word load, with an ifetch waiting behind it.
    tick();
    d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h0000_0500; d_type = 3'b010;
    settle();
    chk1("fl_new_task", mc_new_task, 1'b1);
    chk32("fl_addr", mc_addr, 32'h0000_0500);
    tick();
    i_valid = 1'b1; i_addr = 32'h0000_0600;
    settle();
    chk1("fl_busy_no_issue", mc_new_task, 1'b0);
    tick();
    rob_clear = 1'b1; d_valid = 1'b0;
    settle();
    tick();
    settle();
    chk1("fl_no_d_done", d_done, 1'b0);
    chk1("fl_no_read_issue", mc_new_task, 1'b0);
    tick();
    rob_clear = 1'b0;
    settle();
    chk1("fl_no_d_done2", d_done, 1'b0);
    chk1("fl_if_issue", mc_new_task, 1'b1);
    chk32("fl_if_addr", mc_addr, 32'h0000_0600);
    tick();
    mc_ready = 1'b1; mc_data_out = 32'h7777_8888;
    tick();
    mc_ready = 1'b0; i_valid = 1'b0;
    settle();
    chk1("fl_i_done", i_done, 1'b1);
    chk1("fl_excl_d_done", d_done, 1'b0);
    chk32("fl_i_data", i_data, 32'h7777_8888);

    // Ifetch with a 3-cycle stall: completion slides by 3 cycles.
    tick();
    i_valid = 1'b1; i_addr = 32'h0000_0800;
    settle();
    chk1("st_new_task", mc_new_task, 1'b1);
    tick();
    rdy_in = 1'b0;
    settle();
    chk1("st_no_issue", mc_new_task, 1'b0);
    tick();
    tick();
    settle();
    chk1("st_no_done", i_done, 1'b0);
    tick();
    rdy_in = 1'b1;
    tick();
    tick();
    mc_ready = 1'b1; mc_data_out = 32'h9999_AAAA;
    settle();
    chk1("st_early_done", i_done, 1'b0);
    tick();
    mc_ready = 1'b0; i_valid = 1'b0; rdy_in = 1'b0;
    settle();
    chk1("st_i_done", i_done, 1'b1);
    chk32("st_i_data", i_data, 32'h9999_AAAA);
    tick();
    settle();
    chk1("st_done_no_repeat", i_done, 1'b0);
    chk32("st_i_data_hold", i_data, 32'h9999_AAAA);
    rdy_in = 1'b1;
    tick();
    settle();
    chk1("st_done_once", i_done, 1'b0);

    // Reset in the middle of a word store.
    d_valid = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'h0000_0005;
    d_type = 3'b010;
    settle();
    chk1("rw_new_task", mc_new_task, 1'b1);
    chk1("rw_is_write", mc_is_write, 1'b1);
    tick();
    mc_working = 1'b1;
    settle();
    chk1("rw_busy_no_done", d_done, 1'b0);
    rst_in = 1'b0;
    #1;
    chk1("rw_rst_new_task", mc_new_task, 1'b0);
    chk1("rw_rst_d_done", d_done, 1'b0);
    d_valid = 1'b0; d_write = 1'b0; mc_working = 1'b0;
    #1;
    rst_in = 1'b1;
    tick();
    settle();
    chk1("rw_after_d_done", d_done, 1'b0);
    chk1("rw_after_new_task", mc_new_task, 1'b0);
    tick();
    settle();
    chk1("rw_after_d_done2", d_done, 1'b0);
    // Last grant was data before reset; reset must hand the first tie to data again.
    i_valid = 1'b1; i_addr = 32'h0000_0C00;
    d_valid = 1'b1; d_addr = 32'h0000_0900; d_type = 3'b010;
    settle();
    chk1("rw_idle_issue", mc_new_task, 1'b1);
    chk32("rw_tie_data_first", mc_addr, 32'h0000_0900);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
